// File: rtl/branch_choose_pht.sv
// Tournament chooser table: per-branch saturating counter picking global vs local prediction.
// Entry index travels D/E/M so the M-stage update lands on the entry read in IF.
module branch_choose_pht #(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 10,
  parameter int PC_LSB   = 2,
  parameter int CTR_W    = 2,
  parameter int HIST_W   = 8,
  parameter int HASH_EN  = 1,
  parameter int INIT_VAL = 2 ** (CTR_W - 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pcF,
  input  logic [HIST_W-1:0] ghrF,
  input  logic              stallD,
  input  logic              stallE,
  input  logic              stallM,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              flushM,
  input  logic              branchM,
  input  logic              global_errorM,
  input  logic              local_errorM,
  output logic              pred_chooseD,
  output logic              init_busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  logic [CTR_W-1:0] cpht [DEPTH];

  logic [IDX_W-1:0] pc_slice, idx_f;
  logic             choose_f;
  logic             valid_d, valid_e, valid_m;
  logic [IDX_W-1:0] idx_d, idx_e, idx_m;
  logic             choose_d, choose_e, choose_m;
  logic [CTR_W-1:0] ctr_m, ctr_upd;
  logic             upd_en;
  logic             unused_in;

  assign unused_in = ^{pcF, choose_m};

  assign pc_slice = pcF[PC_LSB +: IDX_W];
  assign idx_f    = (HASH_EN != 0) ? (pc_slice ^ IDX_W'(ghrF)) : pc_slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_cnt <= sweep_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && sweep_cnt == '1) state_nxt = S_RUN;
  end

  assign init_busy = (state == S_INIT);

  // Only a counter that actually moves raises upd_en, so saturation needs no extra write guard.
  assign ctr_m = cpht[idx_m];
  always_comb begin
    ctr_upd = ctr_m;
    upd_en  = 1'b0;
    if (state == S_RUN && branchM && valid_m) begin
      case ({global_errorM, local_errorM})
        2'b01: if (ctr_m != CTR_MAX) begin
          ctr_upd = ctr_m + CTR_W'(1);
          upd_en  = 1'b1;
        end
        2'b10: if (ctr_m != '0) begin
          ctr_upd = ctr_m - CTR_W'(1);
          upd_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write-first: a same-cycle update to the fetched entry is visible to the read.
  always_comb begin
    if (state == S_INIT)                 choose_f = INIT_CTR[CTR_W-1];
    else if (upd_en && idx_f == idx_m)   choose_f = ctr_upd[CTR_W-1];
    else                                 choose_f = cpht[idx_f][CTR_W-1];
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT)  cpht[sweep_cnt] <= INIT_CTR;
    else if (upd_en)      cpht[idx_m]     <= ctr_upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d <= 1'b0; idx_d <= '0; choose_d <= 1'b0;
      valid_e <= 1'b0; idx_e <= '0; choose_e <= 1'b0;
      valid_m <= 1'b0; idx_m <= '0; choose_m <= 1'b0;
    end else begin
      if (flushD) begin
        valid_d <= 1'b0; idx_d <= '0; choose_d <= 1'b0;
      end else if (!stallD) begin
        valid_d <= 1'b1; idx_d <= idx_f; choose_d <= choose_f;
      end
      if (flushE) begin
        valid_e <= 1'b0; idx_e <= '0; choose_e <= 1'b0;
      end else if (!stallE) begin
        valid_e <= valid_d; idx_e <= idx_d; choose_e <= choose_d;
      end
      if (flushM) begin
        valid_m <= 1'b0; idx_m <= '0; choose_m <= 1'b0;
      end else if (!stallM) begin
        valid_m <= valid_e; idx_m <= idx_e; choose_m <= choose_e;
      end
    end
  end

  assign pred_chooseD = choose_d;

endmodule

// File: tb/tb_branch_choose_pht.sv
// Directed bench for branch_choose_pht (IDX_W=5, HIST_W=4, hashed index) with a
// reference counter model and an expected-value queue for pred_chooseD.
module tb_branch_choose_pht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcF;
  logic [3:0]  ghrF;
  logic        stallD, stallE, stallM, flushD, flushE, flushM;
  logic        branchM, global_errorM, local_errorM;
  logic        pred_chooseD, init_busy;

  int errors = 0;
  int checks = 0;
  int mdl [32];
  int busy_cnt = 0;
  logic busy_before = 1'b1;

  typedef struct {string tag; logic exp;} exp_t;
  exp_t sbq [$];

  branch_choose_pht #(
    .PC_W(32), .IDX_W(5), .PC_LSB(2), .CTR_W(2),
    .HIST_W(4), .HASH_EN(1), .INIT_VAL(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .ghrF(ghrF),
    .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .branchM(branchM), .global_errorM(global_errorM), .local_errorM(local_errorM),
    .pred_chooseD(pred_chooseD), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Counts clock edges at which the table was in its sweep state.
  always @(negedge clk) busy_before = init_busy;
  always @(posedge clk) if (rst_n && busy_before) busy_cnt++;

  function automatic int fidx(logic [31:0] pc, logic [3:0] ghr);
    logic [4:0] s;
    s = pc[6:2] ^ {1'b0, ghr};
    return int'(s);
  endfunction

  function automatic logic mdl_msb(int i);
    return (mdl[i] >= 2);
  endfunction

  function automatic void mdl_update(int i, logic g, logic l);
    if ({g, l} == 2'b01 && mdl[i] < 3) mdl[i]++;
    if ({g, l} == 2'b10 && mdl[i] > 0) mdl[i]--;
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 2;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(string tag, logic e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic pop_chk();
    exp_t x;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sbq.pop_front();
      chk(x.tag, {31'd0, pred_chooseD}, {31'd0, x.exp});
    end
  endtask

  // All steps start and end at a falling edge.
  task automatic check_pred(string tag, logic [31:0] pc, logic [3:0] ghr);
    pcF = pc; ghrF = ghr;
    push_exp(tag, mdl_msb(fidx(pc, ghr)));
    @(posedge clk); @(negedge clk);
    pop_chk();
  endtask

  task automatic fetch_update(logic [31:0] pc, logic [3:0] ghr, logic g, logic l,
                              bit apply, bit bypass);
    pcF = pc; ghrF = ghr;
    @(posedge clk); @(negedge clk);
    pcF = 32'h7C; ghrF = 4'h0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    branchM = 1'b1; global_errorM = g; local_errorM = l;
    if (apply) mdl_update(fidx(pc, ghr), g, l);
    if (bypass) begin
      pcF = pc; ghrF = ghr;
      push_exp("bypass_write_first", mdl_msb(fidx(pc, ghr)));
    end
    @(posedge clk); @(negedge clk);
    branchM = 1'b0; global_errorM = 1'b0; local_errorM = 1'b0;
    pcF = 32'h7C; ghrF = 4'h0;
    if (bypass) pop_chk();
  endtask

  task automatic wait_init();
    for (int i = 0; i < 100 && init_busy; i++) @(negedge clk);
    chk("init_done", {31'd0, init_busy}, 32'd0);
    chk("sweep_cycles", busy_cnt, 32);
  endtask

  initial begin
    pcF = 32'h7C; ghrF = 4'h0;
    {stallD, stallE, stallM, flushD, flushE, flushM} = '0;
    branchM = 1'b0; global_errorM = 1'b0; local_errorM = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    chk("reset_pred", {31'd0, pred_chooseD}, 32'd0);
    busy_cnt = 0;
    rst_n = 1'b1;
    mdl_reset();
    wait_init();

    check_pred("post_init_40", 32'h40, 4'h0);
    check_pred("post_init_84", 32'h84, 4'h0);
    check_pred("post_init_7c", 32'h7C, 4'h0);
    check_pred("post_init_hash", 32'h44, 4'h1);

    // Hashed path 0x44^1 targets entry 0x10; entry 0x11 must stay put.
    fetch_update(32'h44, 4'h1, 1'b1, 1'b0, 1, 0);
    check_pred("hash_hits_10", 32'h40, 4'h0);
    check_pred("hash_spares_11", 32'h44, 4'h0);
    fetch_update(32'h44, 4'h1, 1'b1, 1'b0, 1, 0);
    check_pred("toward_local_0", 32'h44, 4'h1);
    fetch_update(32'h40, 4'h0, 1'b1, 1'b0, 1, 0);
    check_pred("sat_low_hold", 32'h40, 4'h0);
    fetch_update(32'h40, 4'h0, 1'b0, 1'b1, 1, 0);
    check_pred("sat_low_no_wrap", 32'h40, 4'h0);
    fetch_update(32'h40, 4'h0, 1'b0, 1'b0, 1, 0);
    check_pred("upd_00_nochange", 32'h40, 4'h0);
    fetch_update(32'h40, 4'h0, 1'b1, 1'b1, 1, 0);
    check_pred("upd_11_nochange", 32'h40, 4'h0);

    // flushE kills the 0x40 entry before M; the 01 update must not land.
    pcF = 32'h40; ghrF = 4'h0;
    @(posedge clk); @(negedge clk);
    pcF = 32'h7C; flushE = 1'b1;
    @(posedge clk); @(negedge clk);
    flushE = 1'b0;
    @(posedge clk); @(negedge clk);
    branchM = 1'b1; global_errorM = 1'b0; local_errorM = 1'b1;
    @(posedge clk); @(negedge clk);
    branchM = 1'b0; local_errorM = 1'b0;
    check_pred("flushE_no_update", 32'h40, 4'h0);

    fetch_update(32'h40, 4'h0, 1'b0, 1'b1, 1, 1);
    fetch_update(32'h40, 4'h0, 1'b0, 1'b1, 1, 0);
    check_pred("toward_global_3", 32'h40, 4'h0);
    fetch_update(32'h40, 4'h0, 1'b0, 1'b1, 1, 0);
    fetch_update(32'h40, 4'h0, 1'b1, 1'b0, 1, 0);
    check_pred("sat_high_no_wrap", 32'h40, 4'h0);
    fetch_update(32'h40, 4'h0, 1'b1, 1'b0, 1, 0);
    check_pred("back_to_local", 32'h40, 4'h0);

    check_pred("stall_setup", 32'h84, 4'h0);
    stallD = 1'b1; pcF = 32'h40;
    push_exp("stallD_hold", 1'b1);
    @(posedge clk); @(negedge clk);
    pop_chk();
    flushD = 1'b1;
    push_exp("flushD_over_stallD", 1'b0);
    @(posedge clk); @(negedge clk);
    pop_chk();
    flushD = 1'b0; stallD = 1'b0;

    // Mid-run reset: sweep restarts and updates issued during it are dropped.
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, init_busy}, 32'd1);
    chk("midrun_reset_pred", {31'd0, pred_chooseD}, 32'd0);
    @(negedge clk);
    busy_cnt = 0;
    rst_n = 1'b1;
    pcF = 32'h40; ghrF = 4'h0;
    push_exp("init_forced_choose", 1'b1);
    @(posedge clk); @(negedge clk);
    pop_chk();
    fetch_update(32'h00, 4'h0, 1'b1, 1'b0, 0, 0);
    mdl_reset();
    wait_init();
    check_pred("init_update_ignored", 32'h00, 4'h0);
    check_pred("reinit_entry_10", 32'h40, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
